// File: rtl/accumulate_arbiter_if.sv
// ============================================================================
// Module  : accumulate_arbiter_if
// Purpose : Requester, result and accumulator-side signals of the arbiter.
//           Carries res_cnt when ACCUMULATE_ARBITER_COUNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface accumulate_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 16
`ifdef ACCUMULATE_ARBITER_COUNT_EN
    ,
    parameter int CW = 8
`endif
);
    logic [N-1:0]   req_stb;
    logic [N*W-1:0] req_dat;
    logic [N-1:0]   req_lst;
    logic [N-1:0]   req_rdy;
    logic [N-1:0]   res_stb;
    logic [W-1:0]   res_dat;
    logic [N-1:0]   res_rdy;
    logic           acc_s_stb;
    logic [W-1:0]   acc_s_dat;
    logic           acc_s_rdy;
    logic           acc_m_stb;
    logic [W-1:0]   acc_m_dat;
    logic           acc_m_rdy;
    logic [N-1:0]   gnt;
    logic           err;

`ifdef ACCUMULATE_ARBITER_COUNT_EN
    logic [CW-1:0]  res_cnt;

    modport slave (
        input  req_stb, req_dat, req_lst, res_rdy, acc_s_rdy, acc_m_stb, acc_m_dat,
        output req_rdy, res_stb, res_dat, acc_s_stb, acc_s_dat, acc_m_rdy, gnt, err, res_cnt
    );
    modport master (
        output req_stb, req_dat, req_lst, res_rdy, acc_s_rdy, acc_m_stb, acc_m_dat,
        input  req_rdy, res_stb, res_dat, acc_s_stb, acc_s_dat, acc_m_rdy, gnt, err, res_cnt
    );
`else
    modport slave (
        input  req_stb, req_dat, req_lst, res_rdy, acc_s_rdy, acc_m_stb, acc_m_dat,
        output req_rdy, res_stb, res_dat, acc_s_stb, acc_s_dat, acc_m_rdy, gnt, err
    );
    modport master (
        output req_stb, req_dat, req_lst, res_rdy, acc_s_rdy, acc_m_stb, acc_m_dat,
        input  req_rdy, res_stb, res_dat, acc_s_stb, acc_s_dat, acc_m_rdy, gnt, err
    );
`endif
endinterface

`default_nettype wire

// File: rtl/accumulate_arbiter.sv
// ============================================================================
// Module  : accumulate_arbiter
// Purpose : Round-robin sharing of one accumulate unit among N burst sources;
//           forwards a burst, forces the flush gap, routes the sum back.
//           Optional beat counter (res_cnt) under ACCUMULATE_ARBITER_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulate_arbiter #(
    parameter int N  = 4,
    parameter int W  = 16
`ifdef ACCUMULATE_ARBITER_COUNT_EN
    ,
    parameter int CW = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    accumulate_arbiter_if.slave   bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          r_state, w_state_nx;
    logic [OW-1:0]   r_owner, w_owner_nx;
    logic [N-1:0]    r_gnt,   w_gnt_nx;
    logic [OW-1:0]   r_ptr,   w_ptr_nx;
    logic            r_err,   w_err_nx;
    logic            r_seen,  w_seen_nx;
`ifdef ACCUMULATE_ARBITER_COUNT_EN
    logic [CW-1:0]   r_cnt,   w_cnt_nx;
`endif

    logic            w_found;
    logic [OW-1:0]   w_winner;
    logic [OW-1:0]   w_ptr_after;
    logic            w_own_stb;
    logic            w_own_lst;

    assign w_own_stb   = bus.req_stb[r_owner];
    assign w_own_lst   = bus.req_lst[r_owner];
    assign w_ptr_after = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;

    // First requester at or after ptr, wrapping modulo N
    always_comb begin
        logic [OW-1:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = OW'((int'(r_ptr) + k) % N);
            if (!w_found && bus.req_stb[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_gnt_nx   = r_gnt;
        w_ptr_nx   = r_ptr;
        w_err_nx   = r_err;
        w_seen_nx  = r_seen;
`ifdef ACCUMULATE_ARBITER_COUNT_EN
        w_cnt_nx   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx           = S_BURST;
                    w_owner_nx           = w_winner;
                    w_gnt_nx             = '0;
                    w_gnt_nx[w_winner]   = 1'b1;
                    w_seen_nx            = 1'b0;
`ifdef ACCUMULATE_ARBITER_COUNT_EN
                    w_cnt_nx             = '0;
`endif
                end
            end
            S_BURST: begin
                if (w_own_stb) begin
                    if (bus.acc_s_rdy) begin
                        w_seen_nx = 1'b1;
`ifdef ACCUMULATE_ARBITER_COUNT_EN
                        if (r_cnt != {CW{1'b1}})
                            w_cnt_nx = r_cnt + 1'b1;
`endif
                        if (w_own_lst)
                            w_state_nx = S_GAP;
                    end
                end else begin
                    // Bubble: flush what was accepted, or abandon an empty burst
                    w_err_nx = 1'b1;
                    if (r_seen) begin
                        w_state_nx = S_GAP;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_gnt_nx   = '0;
                        w_ptr_nx   = w_ptr_after;
                    end
                end
            end
            S_GAP: begin
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.acc_m_stb && bus.res_rdy[r_owner]) begin
                    w_state_nx = S_IDLE;
                    w_gnt_nx   = '0;
                    w_ptr_nx   = w_ptr_after;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_seen  <= 1'b0;
`ifdef ACCUMULATE_ARBITER_COUNT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_gnt   <= w_gnt_nx;
            r_ptr   <= w_ptr_nx;
            r_err   <= w_err_nx;
            r_seen  <= w_seen_nx;
`ifdef ACCUMULATE_ARBITER_COUNT_EN
            r_cnt   <= w_cnt_nx;
`endif
        end
    end

    assign bus.acc_s_stb = (r_state == S_BURST) && w_own_stb;
    assign bus.acc_s_dat = bus.req_dat[int'(r_owner)*W +: W];
    assign bus.req_rdy   = (r_state == S_BURST) ? (r_gnt & {N{bus.acc_s_rdy}}) : '0;
    assign bus.res_stb   = (r_state == S_WAIT)  ? (r_gnt & {N{bus.acc_m_stb}}) : '0;
    assign bus.res_dat   = bus.acc_m_dat;
    assign bus.acc_m_rdy = (r_state == S_WAIT) && bus.res_rdy[r_owner];
    assign bus.gnt       = r_gnt;
    assign bus.err       = r_err;
`ifdef ACCUMULATE_ARBITER_COUNT_EN
    assign bus.res_cnt   = r_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_accumulate_arbiter.sv
// ============================================================================
// Module  : tb_accumulate_arbiter
// Purpose : Self-checking bench for accumulate_arbiter with a saturating
//           accumulator model and a round-robin reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accumulate_arbiter;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXB = 512;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    accumulate_arbiter_if #(.N(N), .W(W)) bus ();
    accumulate_arbiter #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct { int owner; int sum; int cnt; } exp_t;
    exp_t expq[$];
    int   m_ptr;

    typedef struct { int req; int nb; int vals[5]; int exp_sum; int exp_cnt; } vec_t;
    vec_t tbl[6];

    int          bdat[N][MAXB];
    bit          blst[N][MAXB];
    int          rd[N];
    int          wr[N];
    logic [N-1:0] res_rdy_v;
    bit          rnd_en;

    function automatic int sat_add(input int a, input int b);
        int s;
        s = a + b;
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        return s;
    endfunction

    // Accumulator stand-in: saturating sum, emits on the first strobe gap
    int acc_sum;
    bit acc_have;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum       <= 0;
            acc_have      <= 1'b0;
            bus.acc_m_stb <= 1'b0;
            bus.acc_m_dat <= '0;
        end else begin
            if (bus.acc_m_stb && bus.acc_m_rdy)
                bus.acc_m_stb <= 1'b0;
            if (bus.acc_s_stb && bus.acc_s_rdy) begin
                acc_sum  <= sat_add(acc_sum, int'($signed(bus.acc_s_dat)));
                acc_have <= 1'b1;
            end else if (!bus.acc_s_stb && acc_have) begin
                bus.acc_m_stb <= 1'b1;
                bus.acc_m_dat <= W'(acc_sum);
                acc_sum       <= 0;
                acc_have      <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_beat(input int r, input int v, input bit l);
        bdat[r][wr[r]] = v;
        blst[r][wr[r]] = l;
        wr[r]++;
    endtask

    task automatic expect_res(input int owner, input int sum, input int cnt);
        exp_t e;
        e.owner = owner; e.sum = sum; e.cnt = cnt;
        expq.push_back(e);
        m_ptr = (owner + 1) % N;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++)
            if (rd[i] != wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic flush_all();
        for (int i = 0; i < N; i++) rd[i] = wr[i];
        expq.delete();
        m_ptr = 0;
    endtask

    task automatic driver();
        logic [N-1:0] hs;
        forever begin
            @(posedge clk);
            hs = bus.req_stb & bus.req_rdy;
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] === 1'b1 && rd[i] < wr[i]) rd[i]++;
                if (rd[i] < wr[i]) begin
                    bus.req_stb[i]         = 1'b1;
                    bus.req_dat[i*W +: W]  = W'(bdat[i][rd[i]]);
                    bus.req_lst[i]         = blst[i][rd[i]];
                end else begin
                    bus.req_stb[i] = 1'b0;
                    bus.req_lst[i] = 1'b0;
                end
            end
            if (rnd_en) begin
                bus.acc_s_rdy = ($urandom_range(0, 3) != 0);
                bus.res_rdy   = N'($urandom);
            end else begin
                bus.acc_s_rdy = 1'b1;
                bus.res_rdy   = res_rdy_v;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   idx;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_stb != '0) begin
                idx = 0;
                for (int i = N - 1; i >= 0; i--)
                    if (bus.res_stb[i]) idx = i;
                chk("res_onehot", $countones(bus.res_stb), 1);
                if (bus.res_rdy[idx]) begin
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL res_unexpected: got result for req %0d, none expected", idx);
                    end else begin
                        e = expq.pop_front();
                        chk("res_owner", idx, e.owner);
                        chk("res_dat", $signed(bus.res_dat), e.sum);
`ifdef ACCUMULATE_ARBITER_COUNT_EN
                        chk("res_cnt", bus.res_cnt, e.cnt);
`endif
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (expq.size() == 0 && bus.gnt == '0 && queues_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", expq.size());
        end
    endtask

    task automatic wait_gnt(input string name, input int req);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin ok = 1'b1; break; end
        end
        if (ok) chk(name, bus.gnt, 1 << req);
        else begin
            total++; bad++;
            $display("FAIL %s_timeout: got gnt=0 expected %0d", name, 1 << req);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_all();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_vec(input int t, input int req, input int nb, input int v0, input int v1,
                           input int v2, input int v3, input int v4, input int s, input int c);
        tbl[t].req = req; tbl[t].nb = nb;
        tbl[t].vals[0] = v0; tbl[t].vals[1] = v1; tbl[t].vals[2] = v2;
        tbl[t].vals[3] = v3; tbl[t].vals[4] = v4;
        tbl[t].exp_sum = s; tbl[t].exp_cnt = c;
    endtask

    initial begin
        int          p0, subset, nb, sum, v;
        logic [W-1:0] rv;
        bit          ok;

        rst_n         = 1'b0;
        bus.req_stb   = '0;
        bus.req_dat   = '0;
        bus.req_lst   = '0;
        bus.acc_s_rdy = 1'b1;
        bus.res_rdy   = '1;
        res_rdy_v     = '1;
        rnd_en        = 1'b0;
        for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end

        set_vec(0, 0, 3,      3,      5,  -2, 0, 0,      6, 3);
        set_vec(1, 2, 2,  30000,  30000,   0, 0, 0,  32767, 2);
        set_vec(2, 2, 2, -30000, -30000,   0, 0, 0, -32768, 2);
        set_vec(3, 1, 1,      7,      0,   0, 0, 0,      7, 1);
        set_vec(4, 3, 5,      1,      2,   3, 4, 5,     15, 5);
        set_vec(5, 1, 2,   -100,     40,   0, 0, 0,    -60, 2);

        fork
            driver();
            monitor();
        join_none

        do_reset();
        chk("rst_gnt",       bus.gnt,       0);
        chk("rst_req_rdy",   bus.req_rdy,   0);
        chk("rst_res_stb",   bus.res_stb,   0);
        chk("rst_acc_s_stb", bus.acc_s_stb, 0);
        chk("rst_acc_m_rdy", bus.acc_m_rdy, 0);
        chk("rst_err",       bus.err,       0);

        // Single-requester bursts from the table
        for (int t = 0; t < 6; t++) begin
            for (int b = 0; b < tbl[t].nb; b++)
                push_beat(tbl[t].req, tbl[t].vals[b], b == tbl[t].nb - 1);
            expect_res(tbl[t].req, tbl[t].exp_sum, tbl[t].exp_cnt);
            wait_gnt("table_gnt", tbl[t].req);
            wait_idle(200);
            chk("table_gnt_idle", bus.gnt, 0);
        end

        // Simultaneous req1/req3 from reset: 1 first, then 3, then 1 again
        do_reset();
        push_beat(1, 10, 1'b1);
        push_beat(1, 20, 1'b1);
        push_beat(3, 30, 1'b1);
        expect_res(1, 10, 1);
        expect_res(3, 30, 1);
        expect_res(1, 20, 1);
        wait_gnt("rr_first_gnt", 1);
        wait_idle(300);

        // Result held off while another requester waits
        res_rdy_v = 4'b1110;
        push_beat(0, 2, 1'b0);
        push_beat(0, 2, 1'b1);
        expect_res(0, 4, 2);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.res_stb[0]) begin ok = 1'b1; break; end
        end
        chk("hold_res_seen", ok, 1);
        push_beat(1, 9, 1'b1);
        expect_res(1, 9, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_res_stb0", bus.res_stb[0], 1);
            chk("hold_req_rdy1", bus.req_rdy[1], 0);
            chk("hold_gnt",      bus.gnt,        1);
        end
        res_rdy_v = '1;
        wait_idle(200);

        // Bubble after two beats: partial sum returned, err sticks
        push_beat(0, 1, 1'b0);
        push_beat(0, 2, 1'b0);
        expect_res(0, 3, 2);
        wait_idle(200);
        chk("bubble_err", bus.err, 1);
        push_beat(1, 5, 1'b1);
        expect_res(1, 5, 1);
        wait_idle(200);
        chk("bubble_err_sticky", bus.err, 1);

        // Reset in the middle of a burst
        for (int b = 0; b < 6; b++) push_beat(2, 100, b == 5);
        wait_gnt("midrst_gnt", 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt",       bus.gnt,       0);
        chk("midrst_req_rdy",   bus.req_rdy,   0);
        chk("midrst_res_stb",   bus.res_stb,   0);
        chk("midrst_acc_s_stb", bus.acc_s_stb, 0);
        chk("midrst_err",       bus.err,       0);
        flush_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 4; b++) push_beat(2, 1, b == 3);
        expect_res(2, 4, 4);
        wait_idle(200);

        // Random rounds with back-pressure on both sides
        rnd_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            subset = $urandom_range(1, (1 << N) - 1);
            p0 = m_ptr;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (p0 + k) % N;
                if (subset[idx]) begin
                    nb  = $urandom_range(1, 4);
                    sum = 0;
                    for (int b = 0; b < nb; b++) begin
                        rv = W'($urandom);
                        if ($urandom_range(0, 1) == 0) v = int'($signed(rv));
                        else v = $urandom_range(0, 200) - 100;
                        sum = sat_add(sum, v);
                        push_beat(idx, v, b == nb - 1);
                    end
                    expect_res(idx, sum, nb);
                end
            end
            wait_idle(2000);
        end
        rnd_en = 1'b0;
        @(negedge clk);
        chk("rand_err", bus.err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
